mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
Iterative RV32M multiply/divide unit sitting directly downstream of the integer register bank. It consumes the two source operands read on RD1/RD2 and produces a 32-bit writeback value plus a destination index that drive the bank's WD3/A3/WE3 write port. Radix-2 shift-add multiply and restoring divide, one bit per clock. Start/busy/done handshake so the core stalls while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN, counter width = $clog2(XLEN)+1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only on an edge where busy=0
flush  input  1  abort in-flight op (pipeline kill)
op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_val  input  XLEN  operand A (from RD1)
rs2_val  input  XLEN  operand B (from RD2)
rd_in  input  5  destination register index
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse, result valid
result  output  XLEN  writeback data (to WD3)
rd_out  output  5  destination captured at start (to A3)
we  output  1  done && (rd_out != 0) (to WE3)

Behaviour:
- Reset: state=IDLE, busy=0, done=0, we=0, result=0, rd_out=0, counter=0, internal acc/quotient regs=0. Reset has priority over flush and start; mid-operation reset discards the op with no done.
- States: IDLE, CALC, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE: on an edge with start=1, latch op, rd_in, operands; go to CALC (or DONE for a special case, see below). start=0 -> stay.
- Operand prep at accept: MUL/MULH/DIV/REM treat both operands as signed; MULHSU: A signed, B unsigned; MULHU/DIVU/REMU unsigned. Signed operands are converted to magnitude, result sign recorded.
- CALC: one iteration per edge, counter 0..XLEN-1; on the edge completing iteration XLEN-1, apply sign correction, load result, go to DONE.
- Multiply: 2*XLEN-bit product; MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the correctly signed product.
- Divide: DIV/DIVU return quotient, REM/REMU remainder. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A). Truncation toward zero.
- Special cases, resolved at accept and going straight to DONE (latency 1):
  divide by zero: DIV/DIVU -> all ones; REM/REMU -> A unchanged.
  signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- Latency: start accepted on edge N -> done=1 in the cycle after edge N+XLEN (N+32), i.e. 33 cycles total; special cases: done=1 in the cycle after edge N.
- DONE: lasts exactly one cycle, then IDLE. start while busy (CALC or DONE) is ignored, not queued.
- result and rd_out remain stable after done until the next accepted start; we is high only during the done cycle.
- flush: on an edge with flush=1 in CALC or DONE -> IDLE, no done/we pulse, result unchanged. flush and start on the same edge in IDLE -> start ignored. Flush in IDLE has no effect.
- rd_in=0: op runs normally, done pulses, we stays 0.

Test Plan:
- Reset then MUL A=7, B=0xFFFFFFFD, rd=5 -> busy from next cycle; done exactly 33 cycles after the start edge; result=0xFFFFFFEB, rd_out=5, we=1 for one cycle.
- MULH A=B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF and REM 0x80000000/0xFFFFFFFF -> 0, each with done one cycle after the start edge.
- Issue start during CALC with different operands -> ignored, original result delivered. Assert flush at iteration 10 -> no done, busy drops next cycle, result keeps its previous value.
- Assert rst at iteration 20 -> all outputs zero next cycle, no done. Run an op with rd_in=0 -> done=1, we=0.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            accept;
  logic            last_iter;
  logic            is_div;
  logic            sgn_a, sgn_b;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   msum;
  logic [XLEN:0]   drem;
  logic [XLEN:0]   ddiff;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0] dval;
  logic [XLEN-1:0] fin_res;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last_iter = (cnt_q == CW'(XLEN - 1));

  // Operand preparation: signedness, magnitudes and special cases.
  always_comb begin
    is_div = op[2];
    sgn_a  = !(op == 3'd3 || op == 3'd5 || op == 3'd7);
    sgn_b  = (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd6);
    sa     = sgn_a && rs1_val[XLEN-1];
    sb     = sgn_b && rs2_val[XLEN-1];
    mag_a  = sa ? -rs1_val : rs1_val;
    mag_b  = sb ? -rs2_val : rs2_val;
    div_zero = is_div && (rs2_val == '0);
    div_ovf  = (op == 3'd4 || op == 3'd6)
             && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
             && (rs2_val == '1);
    special  = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? rs1_val : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of multiply or divide plus final sign correction.
  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    drem  = {hi_q, lo_q[XLEN-1]};
    ddiff = drem - {1'b0, b_q};
    hi_n  = '0;
    lo_n  = '0;
    if (op_q[2]) begin
      if (!ddiff[XLEN]) begin
        hi_n = ddiff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = drem[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = msum[XLEN:1];
      lo_n = {msum[0], lo_q[XLEN-1:1]};
    end
    full = {hi_n, lo_n};
    if (neg_q)
      full = -full;
    dval = op_q[1] ? hi_n : lo_n;
    if (neg_q)
      dval = -dval;
    if (op_q[2])
      fin_res = dval;
    else if (op_q == 3'd0)
      fin_res = full[XLEN-1:0];
    else
      fin_res = full[2*XLEN-1:XLEN];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (flush)          state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath register updates.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    rd_d  = rd_q;
    neg_d = neg_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    res_d = res_q;
    if (accept) begin
      cnt_d = '0;
      op_d  = op;
      rd_d  = rd_in;
      neg_d = (is_div && op[1]) ? sa : (sa ^ sb);
      hi_d  = '0;
      lo_d  = is_div ? mag_a : mag_b;
      b_d   = is_div ? mag_b : mag_a;
      if (special)
        res_d = special_res;
    end else if (state_q == S_CALC && !flush) begin
      cnt_d = cnt_q + 1'b1;
      hi_d  = hi_n;
      lo_d  = lo_n;
      if (last_iter)
        res_d = fin_res;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= (flush && state_q != S_IDLE) ? S_IDLE : state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    we     = done && (rd_q != 5'd0);
    result = res_q;
    rd_out = rd_q;
  end

endmodule
